// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer. It issues sequential word fetches to a
// variable-latency memory port and queues the returned words in order.
// Each word is presented with its pc and pc+4 through a valid/ready handshake.
// A redirect flushes the queue and discards every response still in flight.
// Optional macro IPB_BYPASS_EN adds a same-cycle path from response to output
// while the queue is empty and no responses are being discarded.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic fifo_empty;
  logic issue;
  logic rsp_accept;
  logic rsp_keep;
  logic rsp_drop;
  logic bypass;
  logic bypass_take;
  logic push;
  logic pop;

  assign fifo_empty = (fifo_count == '0);

  // A response while nothing is outstanding is a protocol error and is ignored.
  assign rsp_accept = mem_rsp_valid && (outstanding != '0);
  assign rsp_drop   = rsp_accept && (drop != '0);
  assign rsp_keep   = rsp_accept && (drop == '0);

  // Credit check counts in-flight requests against free slots, so a returning
  // word always has somewhere to land.
  assign mem_req_valid = reset && !redirect_valid
                      && ((32'(outstanding) + 32'(fifo_count)) < DEPTH)
                      && (32'(outstanding) < MAX_OUTSTANDING);
  assign mem_req_addr  = fetch_pc;
  assign issue         = mem_req_valid && mem_req_ready;

`ifdef IPB_BYPASS_EN
  assign bypass      = fifo_empty && rsp_keep;
  assign bypass_take = bypass && out_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign out_valid = reset && (!fifo_empty || bypass);
  assign pop       = !fifo_empty && out_ready;
  assign push      = rsp_keep && !bypass_take;

  // Output mux: FIFO head, else the bypassed response, else zeros.
  always_comb begin
    out_instr     = '0;
    out_pc        = '0;
    out_pc_plus_4 = '0;
    if (!fifo_empty) begin
      out_instr     = fifo_instr[rd_ptr];
      out_pc        = fifo_pc[rd_ptr];
      out_pc_plus_4 = fifo_pc[rd_ptr] + 32'd4;
    end else if (bypass) begin
      out_instr     = mem_rsp_data;
      out_pc        = rsp_pc;
      out_pc_plus_4 = rsp_pc + 32'd4;
    end
  end

  // In-flight count after this cycle's issue and response.
  always_comb begin
    outstanding_nxt = outstanding;
    if (issue && !rsp_accept) begin
      outstanding_nxt = outstanding + OW'(1);
    end else if (!issue && rsp_accept) begin
      outstanding_nxt = outstanding - OW'(1);
    end
  end

  // Control state: fetch/response pcs, credit counters and FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      rsp_pc      <= RESET_PC & ~32'h3;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old stream.
        fetch_pc   <= {redirect_pc[31:2], 2'b00};
        rsp_pc     <= {redirect_pc[31:2], 2'b00};
        drop       <= outstanding_nxt;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (issue)    fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
        if (rsp_drop) drop     <= drop - OW'(1);
        if (push)     wr_ptr   <= wr_ptr + AW'(1);
        if (pop)      rd_ptr   <= rd_ptr + AW'(1);
        if (push && !pop) begin
          fifo_count <= fifo_count + CW'(1);
        end else if (!push && pop) begin
          fifo_count <= fifo_count - CW'(1);
        end
      end
    end
  end

  // FIFO storage; a write landing during a redirect is discarded by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: queue-based reference model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4)
  );

  typedef struct { logic [31:0] data; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mreq_t       memq[$];
  ent_t        mq[$];
  logic [31:0] lit_q[$];
  logic [31:0] m_fetch_pc, m_rsp_pc;
  int          m_out, m_drop;

  bit          s_req_ready, s_out_ready, s_redir;
  logic [31:0] s_redir_pc;
  int          lat_lo = 1, lat_hi = 1;
  bit          e_rv, e_ov, e_byp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    memq.delete();
    m_fetch_pc = RPC & ~32'h3;
    m_rsp_pc   = RPC & ~32'h3;
    m_out      = 0;
    m_drop     = 0;
  endtask

  // Drive this cycle's inputs, then compare DUT outputs with the model at the falling edge.
  task automatic cyc_begin();
    ent_t h;
    mem_req_ready  = s_req_ready;
    out_ready      = s_out_ready;
    redirect_valid = s_redir;
    redirect_pc    = s_redir_pc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memq[0].data;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    @(negedge clk);
    e_rv  = (reset === 1'b1) && !s_redir && (m_out + mq.size() < DEPTH) && (m_out < MAXO);
    e_byp = 1'b0;
`ifdef IPB_BYPASS_EN
    e_byp = (mq.size() == 0) && (m_drop == 0) && mem_rsp_valid && (m_out > 0);
`endif
    e_ov  = (reset === 1'b1) && (mq.size() > 0 || e_byp);
    chk("mem_req_valid", mem_req_valid, e_rv);
    if (e_rv) chk("mem_req_addr", mem_req_addr, m_fetch_pc);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      if (mq.size() > 0) h = mq[0];
      else begin h.instr = mem_rsp_data; h.pc = m_rsp_pc; end
      chk("out_instr", out_instr, h.instr);
      chk("out_pc", out_pc, h.pc);
      chk("out_pc_plus_4", out_pc_plus_4, h.pc + 32'd4);
    end
  endtask

  // Advance the model by one clock using the rules of the block, then move to the next cycle.
  task automatic cyc_end();
    bit    issue, rsp;
    mreq_t r;
    issue = e_rv && s_req_ready;
    rsp   = mem_rsp_valid && (m_out > 0);
    if (e_ov && s_out_ready && !e_byp) void'(mq.pop_front());
    if (rsp) begin
      void'(memq.pop_front());
      m_out--;
      if (m_drop > 0) m_drop--;
      else begin
        if (!(e_byp && s_out_ready)) mq.push_back('{mem_rsp_data, m_rsp_pc});
        m_rsp_pc = m_rsp_pc + 32'd4;
      end
    end
    if (issue) begin
      if (lit_q.size() > 0) r.data = lit_q.pop_front();
      else r.data = $urandom;
      r.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      memq.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd4;
      m_out++;
    end
    if (s_redir) begin
      mq.delete();
      m_drop     = m_out;
      m_fetch_pc = s_redir_pc & ~32'h3;
      m_rsp_pc   = s_redir_pc & ~32'h3;
    end
    s_redir = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic hard_reset();
    reset          = 1'b0;
    mem_rsp_valid  = 1'b0;
    redirect_valid = 1'b0;
    s_redir        = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    bit found, seen1, seen2;
    reset = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    s_redir = 1'b0; s_redir_pc = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc_plus_4", out_pc_plus_4, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: first two fetches with 1-cycle memory
    s_req_ready = 1'b1; s_out_ready = 1'b0; lat_lo = 1; lat_hi = 1;
    lit_q.push_back(32'h0000_0013);
    lit_q.push_back(32'h0010_0093);
    cyc_begin(); chk("t1_req_valid0", mem_req_valid, 1'b1); chk("t1_addr0", mem_req_addr, 32'h0); cyc_end();
    cyc_begin(); chk("t1_addr1", mem_req_addr, 32'h4); cyc_end();
    s_out_ready = 1'b1;
    cyc_begin();
    chk("t1_valid0", out_valid, 1'b1); chk("t1_pc0", out_pc, 32'h0);
    chk("t1_pc4_0", out_pc_plus_4, 32'h4); chk("t1_instr0", out_instr, 32'h0000_0013);
    cyc_end();
    cyc_begin();
    chk("t1_pc1", out_pc, 32'h4); chk("t1_pc4_1", out_pc_plus_4, 32'h8);
    chk("t1_instr1", out_instr, 32'h0010_0093);
    cyc_end();
    repeat (4) step();

    // 2: back-pressure fills the FIFO, then drains in order
    hard_reset();
    s_out_ready = 1'b0; lat_lo = 1; lat_hi = 2;
    repeat (12) step();
    s_out_ready = 1'b1;
    cyc_begin(); chk("t2_full_no_req", mem_req_valid, 1'b0); chk("t2_head0", out_pc, 32'h0); cyc_end();
    cyc_begin();
    chk("t2_head1", out_pc, 32'h4); chk("t2_resume_valid", mem_req_valid, 1'b1);
    chk("t2_resume_addr", mem_req_addr, 32'h10);
    cyc_end();
    cyc_begin(); chk("t2_head2", out_pc, 32'h8); cyc_end();
    cyc_begin(); chk("t2_head3", out_pc, 32'hC); cyc_end();
    repeat (4) step();

    // 3: redirect with two requests in flight
    hard_reset();
    s_out_ready = 1'b0; lat_lo = 5; lat_hi = 5;
    step(); step();
    s_redir = 1'b1; s_redir_pc = 32'h100;
    cyc_begin(); chk("t3_no_req_on_redirect", mem_req_valid, 1'b0); cyc_end();
    cyc_begin(); chk("t3_fetch_pc", mem_req_addr, 32'h100); chk("t3_flushed", out_valid, 1'b0); cyc_end();
    found = 1'b0; seen1 = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc_begin();
      if (mem_req_valid && !seen1) begin seen1 = 1'b1; chk("t3_first_req", mem_req_addr, 32'h100); end
      if (out_valid) begin found = 1'b1; chk("t3_first_out_pc", out_pc, 32'h100); end
      cyc_end();
    end
    if (!found) chk("t3_timeout_out_valid", out_valid, 1'b1);

    // 4: unaligned redirect target
    s_out_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    s_redir = 1'b1; s_redir_pc = 32'h203;
    step();
    cyc_begin(); chk("t4_fetch_pc", mem_req_addr, 32'h200); cyc_end();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc_begin();
      if (out_valid) begin found = 1'b1; chk("t4_first_out_pc", out_pc, 32'h200); end
      cyc_end();
    end
    if (!found) chk("t4_timeout_out_valid", out_valid, 1'b1);

    // 5: address wrap at the top of the space
    s_out_ready = 1'b0;
    s_redir = 1'b1; s_redir_pc = 32'hFFFF_FFFC;
    step();
    found = 1'b0; seen1 = 1'b0; seen2 = 1'b0;
    for (int i = 0; i < 40 && !(found && seen2); i++) begin
      cyc_begin();
      if (mem_req_valid && mem_req_ready) begin
        if (!seen1) begin seen1 = 1'b1; chk("t5_req0", mem_req_addr, 32'hFFFF_FFFC); end
        else if (!seen2) begin seen2 = 1'b1; chk("t5_req1_wrap", mem_req_addr, 32'h0); end
      end
      if (out_valid && !found) begin
        found = 1'b1;
        chk("t5_out_pc", out_pc, 32'hFFFF_FFFC);
        chk("t5_out_pc_plus_4", out_pc_plus_4, 32'h0);
      end
      cyc_end();
    end
    if (!found) chk("t5_timeout_out_valid", out_valid, 1'b1);

    // 6: asynchronous reset with requests in flight and words buffered
    hard_reset();
    s_out_ready = 1'b0; lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 3 && m_out == 1) break;
      step();
    end
    cyc_begin();
    reset = 1'b0;
    #1;
    chk("t6_async_out_valid", out_valid, 1'b0);
    chk("t6_async_req_valid", mem_req_valid, 1'b0);
    hard_reset();
    cyc_begin(); chk("t6_req_valid", mem_req_valid, 1'b1); chk("t6_req_addr", mem_req_addr, RPC); cyc_end();

    // Randomized traffic with redirects and one mid-run reset
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) hard_reset();
      s_req_ready = ($urandom_range(0, 3) != 0);
      s_out_ready = ((i / 200) % 3 == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        s_redir    = 1'b1;
        s_redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
